br_result_collector: RTL and testbench

//  Producer side of the branch-result update interface consumed by the PHT/BTB predictors. Collects

---
 rtl/br_result_collector_pkg.sv | 22 ++
 rtl/br_result_fifo.sv | 64 ++++++
 rtl/br_result_collector.sv | 146 ++++++++++++++
 tb/tb_br_result_collector.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/br_result_collector_pkg.sv
// Shared types for the branch-result collector: queued entry layout and
// the mispredict classification used at enqueue.
package br_result_collector_pkg;

  localparam int unsigned ADDR_WIDTH            = 32;
  localparam int unsigned PHT_ENTRY_WIDTH       = 2;
  localparam int unsigned BR_RESULT_QUEUE_DEPTH = 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]      br_addr;
    logic                       exec_taken;
    logic                       mispred;
    logic [PHT_ENTRY_WIDTH-1:0] pht_prev_value;
  } br_exec_entry_t;

  // Wrong direction, or taken to a target the predictor did not supply.
  function automatic logic calc_mispred(input logic taken, input logic pred_taken,
                                        input logic target_ok);
    return (taken != pred_taken) | (taken & ~target_ok);
  endfunction

endpackage

// File: rtl/br_result_fifo.sv
// Multi-push / multi-pop circular buffer of branch-result entries.
// The caller guarantees push never overfills and pop never exceeds count.
module br_result_fifo
  import br_result_collector_pkg::*;
#(
  parameter int unsigned Depth    = BR_RESULT_QUEUE_DEPTH,
  parameter int unsigned InWidth  = 2,
  parameter int unsigned OutWidth = 2,
  localparam int unsigned PtrW    = $clog2(Depth),
  localparam int unsigned CntW    = PtrW + 1,
  localparam int unsigned PushW   = $clog2(InWidth + 1),
  localparam int unsigned PopW    = $clog2(OutWidth + 1)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_flush,
  input  logic [PushW-1:0]                    i_push_count,
  input  br_exec_entry_t [InWidth-1:0]        i_push_data,
  input  logic [PopW-1:0]                     i_pop_count,
  output br_exec_entry_t [OutWidth-1:0]       o_head_data,
  output logic [CntW-1:0]                     o_count
);

  br_exec_entry_t        r_mem [Depth];
  logic [PtrW-1:0]       r_head;
  logic [PtrW-1:0]       r_tail;
  logic [CntW-1:0]       r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PtrW'(i_pop_count);
      r_tail  <= r_tail + PtrW'(i_push_count);
      r_count <= r_count + CntW'(i_push_count) - CntW'(i_pop_count);
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge i_clk) begin
    if (!i_flush) begin
      for (int i = 0; i < InWidth; i++) begin
        if (PushW'(i) < i_push_count) begin
          r_mem[r_tail + PtrW'(i)] <= i_push_data[i];
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < OutWidth; j++) begin
      o_head_data[j] = r_mem[r_head + PtrW'(j)];
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/br_result_collector.sv
// Collects resolved branches from the execute lanes, classifies mispredicts,
// queues them in program order and drives registered brResult lanes.
module br_result_collector
  import br_result_collector_pkg::*;
#(
  parameter int unsigned InWidth    = 2,
  parameter int unsigned OutWidth   = 2,
  parameter int unsigned QueueDepth = BR_RESULT_QUEUE_DEPTH
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_flush,
  input  logic [InWidth-1:0]                  i_ex_valid,
  input  logic [InWidth*ADDR_WIDTH-1:0]       i_ex_br_addr,
  input  logic [InWidth-1:0]                  i_ex_taken,
  input  logic [InWidth-1:0]                  i_ex_pred_taken,
  input  logic [InWidth-1:0]                  i_ex_target_ok,
  input  logic [InWidth*PHT_ENTRY_WIDTH-1:0]  i_ex_pht_prev,
  output logic                                o_ex_ready,
  input  logic                                i_upd_stall,
  output logic [OutWidth-1:0]                 o_br_valid,
  output logic [OutWidth*ADDR_WIDTH-1:0]      o_br_addr,
  output logic [OutWidth-1:0]                 o_br_exec_taken,
  output logic [OutWidth-1:0]                 o_br_mispred,
  output logic [OutWidth*PHT_ENTRY_WIDTH-1:0] o_br_pht_prev,
  output logic                                o_overflow
);

  localparam int unsigned PtrW  = $clog2(QueueDepth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned PushW = $clog2(InWidth + 1);
  localparam int unsigned PopW  = $clog2(OutWidth + 1);
  localparam int unsigned IdxW  = (InWidth > 1) ? $clog2(InWidth) : 1;

  br_exec_entry_t [InWidth-1:0]  w_push_data;
  br_exec_entry_t [OutWidth-1:0] w_head_data;
  logic [PushW-1:0]              w_push_count;
  logic [PopW-1:0]               w_pop_count;
  logic [CntW-1:0]               w_count;
  logic [OutWidth-1:0]           w_sel_valid;
  logic                          w_accept;
  logic                          w_stop;
  logic                          w_drop;

  br_exec_entry_t [OutWidth-1:0] r_out;
  logic [OutWidth-1:0]           r_out_valid;
  logic                          r_overflow;

  assign o_ex_ready = (CntW'(QueueDepth) - w_count) >= CntW'(InWidth);
  assign w_accept   = o_ex_ready && !i_flush;
  assign w_drop     = !i_flush && (|i_ex_valid) && !o_ex_ready;

  // Pack valid lanes into consecutive slots, lowest lane first.
  always_comb begin
    w_push_data  = '0;
    w_push_count = '0;
    for (int i = 0; i < InWidth; i++) begin
      if (i_ex_valid[i]) begin
        w_push_data[IdxW'(w_push_count)].br_addr =
            i_ex_br_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_push_data[IdxW'(w_push_count)].exec_taken = i_ex_taken[i];
        w_push_data[IdxW'(w_push_count)].mispred =
            calc_mispred(i_ex_taken[i], i_ex_pred_taken[i], i_ex_target_ok[i]);
        w_push_data[IdxW'(w_push_count)].pht_prev_value =
            i_ex_pht_prev[i*PHT_ENTRY_WIDTH +: PHT_ENTRY_WIDTH];
        w_push_count = w_push_count + PushW'(1);
      end
    end
    if (!w_accept) begin
      w_push_count = '0;
    end
  end

  // Take head entries in order; a mispredict ends the group so the predictor
  // sees it before any younger result.
  always_comb begin
    w_sel_valid = '0;
    w_pop_count = '0;
    w_stop      = 1'b0;
    for (int j = 0; j < OutWidth; j++) begin
      if (!w_stop && (CntW'(j) < w_count)) begin
        w_sel_valid[j] = 1'b1;
        w_pop_count    = w_pop_count + PopW'(1);
        if (w_head_data[j].mispred) begin
          w_stop = 1'b1;
        end
      end
    end
    if (i_upd_stall || i_flush) begin
      w_pop_count = '0;
    end
  end

  br_result_fifo #(
    .Depth    (QueueDepth),
    .InWidth  (InWidth),
    .OutWidth (OutWidth)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_flush      (i_flush),
    .i_push_count (w_push_count),
    .i_push_data  (w_push_data),
    .i_pop_count  (w_pop_count),
    .o_head_data  (w_head_data),
    .o_count      (w_count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= '0;
      r_out       <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (i_flush) begin
        r_out_valid <= '0;
        r_out       <= '0;
      end else if (!i_upd_stall) begin
        r_out_valid <= w_sel_valid;
        for (int j = 0; j < OutWidth; j++) begin
          r_out[j] <= w_sel_valid[j] ? w_head_data[j] : '0;
        end
      end
    end
  end

  always_comb begin
    o_br_valid      = r_out_valid;
    o_br_addr       = '0;
    o_br_exec_taken = '0;
    o_br_mispred    = '0;
    o_br_pht_prev   = '0;
    for (int j = 0; j < OutWidth; j++) begin
      o_br_addr[j*ADDR_WIDTH +: ADDR_WIDTH]                = r_out[j].br_addr;
      o_br_exec_taken[j]                                   = r_out[j].exec_taken;
      o_br_mispred[j]                                      = r_out[j].mispred;
      o_br_pht_prev[j*PHT_ENTRY_WIDTH +: PHT_ENTRY_WIDTH]  = r_out[j].pht_prev_value;
    end
  end

  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_br_result_collector.sv
// Directed bench for br_result_collector with hand-computed expectations.
module tb_br_result_collector;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  ex_valid;
  logic [63:0] ex_br_addr;
  logic [1:0]  ex_taken;
  logic [1:0]  ex_pred_taken;
  logic [1:0]  ex_target_ok;
  logic [3:0]  ex_pht_prev;
  logic        ex_ready;
  logic        upd_stall;
  logic [1:0]  br_valid;
  logic [63:0] br_addr;
  logic [1:0]  br_exec_taken;
  logic [1:0]  br_mispred;
  logic [3:0]  br_pht_prev;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  br_result_collector dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_flush         (flush),
    .i_ex_valid      (ex_valid),
    .i_ex_br_addr    (ex_br_addr),
    .i_ex_taken      (ex_taken),
    .i_ex_pred_taken (ex_pred_taken),
    .i_ex_target_ok  (ex_target_ok),
    .i_ex_pht_prev   (ex_pht_prev),
    .o_ex_ready      (ex_ready),
    .i_upd_stall     (upd_stall),
    .o_br_valid      (br_valid),
    .o_br_addr       (br_addr),
    .o_br_exec_taken (br_exec_taken),
    .o_br_mispred    (br_mispred),
    .o_br_pht_prev   (br_pht_prev),
    .o_overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ex_valid      = '0;
    ex_br_addr    = '0;
    ex_taken      = '0;
    ex_pred_taken = '0;
    ex_target_ok  = '0;
    ex_pht_prev   = '0;
  endtask

  task automatic set_lane(input int lane, input logic [31:0] addr, input logic taken,
                          input logic pred, input logic tgt_ok, input logic [1:0] pht);
    ex_valid[lane]            = 1'b1;
    ex_br_addr[lane*32 +: 32] = addr;
    ex_taken[lane]            = taken;
    ex_pred_taken[lane]       = pred;
    ex_target_ok[lane]        = tgt_ok;
    ex_pht_prev[lane*2 +: 2]  = pht;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    upd_stall = 1'b0;
    clear_in();
    #1;
    check("reset_valid", 64'(br_valid), 64'h0);
    check("reset_ready", 64'(ex_ready), 64'h1);
    check("reset_ovf", 64'(overflow), 64'h0);
    #2 rst = 1'b0;

    // 1: single correct prediction, two-edge latency
    set_lane(0, 32'h1000, 1'b1, 1'b1, 1'b1, 2'd2);
    step();
    clear_in();
    check("t1_not_yet", 64'(br_valid), 64'h0);
    step();
    check("t1_valid", 64'(br_valid), 64'h1);
    check("t1_addr", 64'(br_addr[31:0]), 64'h1000);
    check("t1_taken", 64'(br_exec_taken[0]), 64'h1);
    check("t1_mispred", 64'(br_mispred[0]), 64'h0);
    check("t1_pht", 64'(br_pht_prev[1:0]), 64'h2);
    step();
    check("t1_idle", 64'(br_valid), 64'h0);

    // 2: two lanes, lane1 direction mispredict
    set_lane(0, 32'h2000, 1'b0, 1'b0, 1'b1, 2'd1);
    set_lane(1, 32'h2004, 1'b1, 1'b0, 1'b1, 2'd3);
    step();
    clear_in();
    step();
    check("t2_valid", 64'(br_valid), 64'h3);
    check("t2_mispred", 64'(br_mispred), 64'h2);
    check("t2_taken", 64'(br_exec_taken), 64'h2);
    check("t2_addr", br_addr, 64'h0000_2004_0000_2000);
    check("t2_pht", 64'(br_pht_prev), 64'hD);
    step();
    check("t2_idle", 64'(br_valid), 64'h0);

    // 3: mispredict at head stops the group
    upd_stall = 1'b1;
    set_lane(0, 32'h3000, 1'b1, 1'b0, 1'b1, 2'd0);
    set_lane(1, 32'h3004, 1'b0, 1'b0, 1'b1, 2'd1);
    step();
    clear_in();
    set_lane(1, 32'h3008, 1'b1, 1'b1, 1'b0, 2'd2);
    step();
    clear_in();
    step();
    check("t3_stall_hold", 64'(br_valid), 64'h0);
    upd_stall = 1'b0;
    step();
    check("t3_c1_valid", 64'(br_valid), 64'h1);
    check("t3_c1_addr", 64'(br_addr[31:0]), 64'h3000);
    check("t3_c1_mispred", 64'(br_mispred), 64'h1);
    step();
    check("t3_c2_valid", 64'(br_valid), 64'h3);
    check("t3_c2_addr", br_addr, 64'h0000_3008_0000_3004);
    check("t3_c2_mispred", 64'(br_mispred), 64'h2);
    step();
    check("t3_idle", 64'(br_valid), 64'h0);

    // 4: fill to depth, then drop a group
    upd_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t4_ready_before", 64'(ex_ready), 64'h1);
      set_lane(0, 32'h4000 + 32'(8 * k), 1'b1, 1'b1, 1'b1, 2'd3);
      set_lane(1, 32'h4004 + 32'(8 * k), 1'b1, 1'b1, 1'b1, 2'd3);
      step();
    end
    check("t4_full_ready", 64'(ex_ready), 64'h0);
    check("t4_ovf_before", 64'(overflow), 64'h0);
    set_lane(0, 32'h5000, 1'b1, 1'b1, 1'b1, 2'd0);
    set_lane(1, 32'h5004, 1'b1, 1'b1, 1'b1, 2'd0);
    step();
    clear_in();
    check("t4_ovf", 64'(overflow), 64'h1);
    check("t4_still_full", 64'(ex_ready), 64'h0);
    upd_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t4_drain_valid", 64'(br_valid), 64'h3);
      check("t4_drain_addr", br_addr,
            {32'h4004 + 32'(8 * k), 32'h4000 + 32'(8 * k)});
    end
    step();
    check("t4_drained", 64'(br_valid), 64'h0);

    // 5: flush clears held outputs and queue under stall
    set_lane(0, 32'h6100, 1'b0, 1'b0, 1'b1, 2'd1);
    step();
    clear_in();
    step();
    check("t5_pre_valid", 64'(br_valid), 64'h1);
    upd_stall = 1'b1;
    set_lane(0, 32'h6000, 1'b0, 1'b0, 1'b1, 2'd0);
    set_lane(1, 32'h6004, 1'b0, 1'b0, 1'b1, 2'd0);
    step();
    step();
    clear_in();
    set_lane(0, 32'h6010, 1'b0, 1'b0, 1'b1, 2'd0);
    step();
    clear_in();
    check("t5_hold_valid", 64'(br_valid), 64'h1);
    check("t5_ready_5q", 64'(ex_ready), 64'h1);
    flush = 1'b1;
    set_lane(0, 32'h6020, 1'b1, 1'b0, 1'b1, 2'd0);
    set_lane(1, 32'h6024, 1'b1, 1'b0, 1'b1, 2'd0);
    step();
    flush = 1'b0;
    clear_in();
    check("t5_flush_valid", 64'(br_valid), 64'h0);
    check("t5_flush_ready", 64'(ex_ready), 64'h1);
    check("t5_flush_ovf", 64'(overflow), 64'h1);
    upd_stall = 1'b0;
    step();
    check("t5_empty", 64'(br_valid), 64'h0);

    // 6: async reset between edges mid-drain
    upd_stall = 1'b1;
    set_lane(0, 32'h7000, 1'b0, 1'b0, 1'b1, 2'd1);
    set_lane(1, 32'h7004, 1'b0, 1'b0, 1'b1, 2'd1);
    step();
    step();
    clear_in();
    upd_stall = 1'b0;
    step();
    check("t6_draining", 64'(br_valid), 64'h3);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(br_valid), 64'h0);
    check("t6_rst_ready", 64'(ex_ready), 64'h1);
    check("t6_rst_ovf", 64'(overflow), 64'h0);
    #1 rst = 1'b0;
    step();
    check("t6_after_rst", 64'(br_valid), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
